// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks one outstanding multi-cycle op and stalls ID on RAW/WAW/structural hazards
module hazard_scoreboard (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    input  logic        issue_mc,
    input  logic [4:0]  issue_rd,
    input  logic        issue_fp,
    input  logic [4:0]  rs1_id,
    input  logic [4:0]  rs2_id,
    input  logic [1:0]  rs_used,
    input  logic [1:0]  float_read,
    input  logic        mc_done,
    input  logic        cnt_clr,
    output logic        id_stall,
    output logic        pc_stall,
    output logic        pipe_hold,
    output logic        wb_sel_mc,
    output logic [4:0]  wb_rd,
    output logic        wb_fp,
    output logic        busy,
    output logic [15:0] stall_cnt
);
    typedef enum logic [1:0] {IDLE, BUSY, WB} state_t;
    state_t     state;
    logic       pend_v;
    logic [4:0] pend_rd;
    logic       pend_fp;
    logic       raw;
    logic       waw;
    logic       str_haz;
    logic       stall;
    // hazard detection against the single pending destination
    always_comb begin
        raw     = pend_v && ((rs_used[1] && rs1_id == pend_rd && float_read[1] == pend_fp) ||
                             (rs_used[0] && rs2_id == pend_rd && float_read[0] == pend_fp));
        waw     = issue_valid && pend_v && issue_rd == pend_rd && issue_fp == pend_fp;
        str_haz = issue_valid && issue_mc && state != IDLE;
        stall   = raw || waw || str_haz || state == WB;
    end
    assign id_stall = stall;
    assign pc_stall = stall;
    assign wb_rd    = pend_rd;
    assign wb_fp    = pend_fp;
    // issue / wait / writeback sequencing; integer x0 is never marked pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pend_v    <= 1'b0;
            pend_rd   <= 5'd0;
            pend_fp   <= 1'b0;
            wb_sel_mc <= 1'b0;
            pipe_hold <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (issue_valid && issue_mc && !stall) begin
                    pend_rd <= issue_rd;
                    pend_fp <= issue_fp;
                    pend_v  <= (issue_rd != 5'd0) || issue_fp;
                    busy    <= 1'b1;
                    state   <= BUSY;
                end
                BUSY: if (mc_done) begin
                    wb_sel_mc <= 1'b1;
                    pipe_hold <= 1'b1;
                    state     <= WB;
                end
                WB: begin
                    pend_v    <= 1'b0;
                    wb_sel_mc <= 1'b0;
                    pipe_hold <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // saturating stall-cycle counter, clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt <= 16'd0;
        else stall_cnt <= cnt_clr ? 16'd0 : (stall && stall_cnt != 16'hFFFF) ? stall_cnt + 16'd1 : stall_cnt;
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed checks of issue, hazards, writeback, reset and counter saturation
module tb_hazard_scoreboard;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_mc = 1'b0;
    logic [4:0]  issue_rd = 5'd0;
    logic        issue_fp = 1'b0;
    logic [4:0]  rs1_id = 5'd0;
    logic [4:0]  rs2_id = 5'd0;
    logic [1:0]  rs_used = 2'b00;
    logic [1:0]  float_read = 2'b00;
    logic        mc_done = 1'b0;
    logic        cnt_clr = 1'b0;
    logic        id_stall;
    logic        pc_stall;
    logic        pipe_hold;
    logic        wb_sel_mc;
    logic [4:0]  wb_rd;
    logic        wb_fp;
    logic        busy;
    logic [15:0] stall_cnt;
    int checks = 0;
    int errors = 0;

    hazard_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_mc(issue_mc),
        .issue_rd(issue_rd), .issue_fp(issue_fp), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs_used(rs_used), .float_read(float_read), .mc_done(mc_done), .cnt_clr(cnt_clr),
        .id_stall(id_stall), .pc_stall(pc_stall), .pipe_hold(pipe_hold), .wb_sel_mc(wb_sel_mc),
        .wb_rd(wb_rd), .wb_fp(wb_fp), .busy(busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic mc, input logic [4:0] rd, input logic fp);
        issue_valid = 1'b1;
        issue_mc = mc;
        issue_rd = rd;
        issue_fp = fp;
    endtask

    task automatic no_issue();
        issue_valid = 1'b0;
        issue_mc = 1'b0;
        issue_rd = 5'd0;
        issue_fp = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_stall", id_stall, 0);
        chk("rst_pcstall", pc_stall, 0);
        chk("rst_cnt", stall_cnt, 0);
        chk("rst_wbsel", wb_sel_mc, 0);
        chk("rst_hold", pipe_hold, 0);
        chk("rst_wbrd", wb_rd, 0);
        tick();
        rst_n = 1'b1;
        tick();
        // cycle 0: div x5
        issue(1'b1, 5'd5, 1'b0);
        #1;
        chk("c0_nostall", id_stall, 0);
        tick();
        // cycle 1: add x6,x5,x1 waits in ID
        issue(1'b0, 5'd6, 1'b0);
        rs1_id = 5'd5;
        rs2_id = 5'd1;
        rs_used = 2'b11;
        float_read = 2'b00;
        for (int c = 1; c <= 10; c++) begin
            #1;
            chk("busy_c", busy, 1);
            chk("raw_stall", id_stall, 1);
            chk("raw_pcstall", pc_stall, 1);
            chk("no_wb_busy", wb_sel_mc, 0);
            if (c == 10) mc_done = 1'b1;
            tick();
        end
        mc_done = 1'b0;
        // cycle 11: WB
        chk("c11_busy", busy, 1);
        chk("c11_wbsel", wb_sel_mc, 1);
        chk("c11_hold", pipe_hold, 1);
        chk("c11_wbrd", wb_rd, 5);
        chk("c11_wbfp", wb_fp, 0);
        chk("c11_stall", id_stall, 1);
        tick();
        // cycle 12: IDLE
        chk("c12_busy", busy, 0);
        chk("c12_wbsel", wb_sel_mc, 0);
        chk("c12_hold", pipe_hold, 0);
        chk("c12_stall", id_stall, 0);
        chk("c12_cnt", stall_cnt, 11);
        chk("c12_wbrd_hold", wb_rd, 5);
        no_issue();
        rs_used = 2'b00;
        mc_done = 1'b1;
        tick();
        mc_done = 1'b0;
        chk("idle_mcdone_busy", busy, 0);
        chk("idle_mcdone_wb", wb_sel_mc, 0);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("cnt_clr", stall_cnt, 0);
        // fdiv f5
        issue(1'b1, 5'd5, 1'b1);
        tick();
        no_issue();
        chk("f5_busy", busy, 1);
        rs1_id = 5'd5;
        rs_used = 2'b10;
        float_read = 2'b00;
        #1;
        chk("int_x5_vs_f5", id_stall, 0);
        float_read = 2'b10;
        #1;
        chk("float_f5_raw", id_stall, 1);
        rs_used = 2'b00;
        float_read = 2'b00;
        rs2_id = 5'd5;
        rs_used = 2'b01;
        float_read = 2'b01;
        #1;
        chk("rs2_f5_raw", id_stall, 1);
        rs_used = 2'b00;
        float_read = 2'b00;
        issue(1'b0, 5'd5, 1'b1);
        #1;
        chk("waw_f5", id_stall, 1);
        issue(1'b0, 5'd5, 1'b0);
        #1;
        chk("no_waw_x5", id_stall, 0);
        // second mc op during BUSY with mc_done the same cycle
        issue(1'b1, 5'd7, 1'b0);
        mc_done = 1'b1;
        #1;
        chk("struct_stall", id_stall, 1);
        tick();
        mc_done = 1'b0;
        chk("struct_wbsel", wb_sel_mc, 1);
        chk("struct_wbrd", wb_rd, 5);
        chk("struct_wbfp", wb_fp, 1);
        chk("struct_wb_stall", id_stall, 1);
        tick();
        chk("struct_idle", busy, 0);
        chk("struct_accept", id_stall, 0);
        tick();
        no_issue();
        chk("second_busy", busy, 1);
        chk("second_rd", wb_rd, 7);
        chk("second_fp", wb_fp, 0);
        mc_done = 1'b1;
        tick();
        mc_done = 1'b0;
        tick();
        chk("second_done", busy, 0);
        // integer x0 destination never pending
        issue(1'b1, 5'd0, 1'b0);
        tick();
        no_issue();
        chk("x0_busy", busy, 1);
        rs1_id = 5'd0;
        rs_used = 2'b10;
        float_read = 2'b00;
        #1;
        chk("x0_read", id_stall, 0);
        rs_used = 2'b00;
        issue(1'b0, 5'd0, 1'b0);
        #1;
        chk("x0_waw", id_stall, 0);
        no_issue();
        mc_done = 1'b1;
        tick();
        mc_done = 1'b0;
        tick();
        // f0 is an ordinary register
        issue(1'b1, 5'd0, 1'b1);
        tick();
        no_issue();
        rs1_id = 5'd0;
        rs_used = 2'b10;
        float_read = 2'b10;
        #1;
        chk("f0_raw", id_stall, 1);
        rs_used = 2'b00;
        float_read = 2'b00;
        mc_done = 1'b1;
        tick();
        mc_done = 1'b0;
        tick();
        // reset in the middle of BUSY
        issue(1'b1, 5'd9, 1'b0);
        tick();
        no_issue();
        rs1_id = 5'd9;
        rs_used = 2'b10;
        #1;
        chk("pre_rst_rd", wb_rd, 9);
        chk("pre_rst_stall", id_stall, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_stall", id_stall, 0);
        chk("mid_rst_pcstall", pc_stall, 0);
        chk("mid_rst_rd", wb_rd, 0);
        chk("mid_rst_cnt", stall_cnt, 0);
        tick();
        rst_n = 1'b1;
        mc_done = 1'b1;
        tick();
        mc_done = 1'b0;
        chk("post_rst_nowb", wb_sel_mc, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_stall", id_stall, 0);
        tick();
        chk("post_rst_nowb2", wb_sel_mc, 0);
        chk("post_rst_hold2", pipe_hold, 0);
        // saturation of stall_cnt over 70000 stalled cycles
        rs_used = 2'b00;
        issue(1'b1, 5'd3, 1'b0);
        tick();
        no_issue();
        rs1_id = 5'd3;
        rs_used = 2'b10;
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("sat_start", stall_cnt, 0);
        repeat (65534) tick();
        chk("sat_fffe", stall_cnt, 16'hFFFE);
        repeat (70000 - 65534) tick();
        chk("sat_ffff", stall_cnt, 16'hFFFF);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("sat_clr", stall_cnt, 0);
        rs_used = 2'b00;
        mc_done = 1'b1;
        tick();
        mc_done = 1'b0;
        tick();
        chk("final_idle", busy, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have port clk, input, 1, single core clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-003 SHALL have port issue_valid, input, 1, the ID-stage instruction is valid and committed (never flushed after this point).
REQ-004 SHALL have port issue_mc, input, 1, the ID instruction is multi-cycle (integer div/rem, FP div/sqrt).
REQ-005 SHALL have port issue_rd, input, 5, destination register of the ID instruction.
REQ-006 SHALL have port issue_fp, input, 1, issue_rd is in the float register file.
REQ-007 SHALL have port rs1_id and rs2_id, input, 5 each, ID source registers.
REQ-008 SHALL have port rs_used, input, 2, bit1 = rs1 read, bit0 = rs2 read.
REQ-009 SHALL have port float_read, input, 2, bit1 = rs1 from float file, bit0 = rs2 from float file.
REQ-010 SHALL have port mc_done, input, 1, single-cycle pulse: the multi-cycle unit result is ready.
REQ-011 SHALL have port cnt_clr, input, 1, synchronous clear of stall_cnt.
REQ-012 SHALL have port id_stall and pc_stall, output, 1 each, hold the ID register and PC.
REQ-013 SHALL have port pipe_hold, output, 1, freeze EX/MEM/WB for one cycle.
REQ-014 SHALL have port wb_sel_mc, output, 1, the writeback port selects the multi-cycle result.
REQ-015 SHALL have port wb_rd, output, 5, and wb_fp, output, 1, the multi-cycle destination.
REQ-016 SHALL have port busy, output, 1, high when state is not IDLE.
REQ-017 SHALL have port stall_cnt, output, 16, count of stalled cycles.

Function
REQ-018 SHALL implement states IDLE, BUSY and WB; at most one multi-cycle operation is outstanding.
REQ-019 SHALL, in IDLE with issue_valid=1, issue_mc=1 and id_stall=0, latch issue_rd/issue_fp into pend_rd/pend_fp, set pend_v=1 and enter BUSY next cycle.
REQ-020 SHALL NOT set pend_v when issue_rd=0 and issue_fp=0; the op still enters BUSY.
REQ-021 SHALL remain in BUSY until mc_done=1, then enter WB.
REQ-022 SHALL ignore mc_done while in IDLE or WB.
REQ-023 SHALL hold WB for exactly one cycle with wb_sel_mc=1, pipe_hold=1, wb_rd=pend_rd and wb_fp=pend_fp.
REQ-024 SHALL leave WB for IDLE, clearing pend_v on that same edge.
REQ-025 SHALL detect a RAW hazard when pend_v=1 and, for either source n, rs_used[n]=1, rs_n equals pend_rd and float_read[n] equals pend_fp.
REQ-026 SHALL detect a WAW hazard when issue_valid=1, pend_v=1, issue_rd equals pend_rd and issue_fp equals pend_fp.
REQ-027 SHALL detect a structural hazard when issue_valid=1, issue_mc=1 and state is not IDLE.
REQ-028 SHALL assert id_stall and pc_stall, both combinational and identical, when any of RAW, WAW or structural holds, or when state=WB.
REQ-029 SHALL drive wb_sel_mc=0 and pipe_hold=0 outside WB; wb_rd and wb_fp then hold the last latched values.
REQ-030 SHALL treat integer x0 as never pending, so reads of x0 never stall; float f0 is a normal register.
REQ-031 SHALL handle mc_done in the same cycle as a new mc issue in BUSY as structural: the issue stalls and the state moves to WB.
REQ-032 SHALL increment stall_cnt each cycle id_stall=1, saturating at 0xFFFF.
REQ-033 SHALL give cnt_clr priority over the increment, so stall_cnt is 0 on the next cycle.

Reset
REQ-034 SHALL, while rst_n=0, immediately force state=IDLE, pend_v=0, pend_rd=0, pend_fp=0, stall_cnt=0, wb_sel_mc=0, pipe_hold=0, id_stall=0, pc_stall=0 and busy=0.
REQ-035 SHALL abandon an in-flight operation when reset is asserted mid-BUSY or mid-WB, with no writeback after release.
REQ-036 SHALL begin normal operation on the first rising clk edge after rst_n rises.

Verification
REQ-037 SHALL be verified by issuing a div to x5 (int) at cycle 0 with mc_done at cycle 10 -> busy=1 for cycles 1-11, WB at cycle 11 with wb_rd=5 and wb_sel_mc=1, IDLE at cycle 12.
REQ-038 SHALL be verified by holding an add x6,x5,x1 in ID during BUSY for the x5 op -> id_stall=pc_stall=1 until WB ends, stall=0 at cycle 12, stall_cnt increments per stalled cycle.
REQ-039 SHALL be verified with pending f5 while ID reads integer x5 (float_read=00) -> no stall; the same read with float_read=10 -> stall.
REQ-040 SHALL be verified by issuing a second mc op during BUSY with mc_done in the same cycle -> structural stall, then WB, then the second op is accepted in IDLE the next cycle.
REQ-041 SHALL be verified by driving rst_n low in BUSY (pend_rd=9) -> outputs reset immediately, and mc_done after release produces no WB.
REQ-042 SHALL be verified by forcing 70000 continuous stall cycles -> stall_cnt=0xFFFF, and cnt_clr -> 0 the next cycle.
